// File: rtl/imem_loader_pkg.sv
// Shared constants, state encodings and bit-timing helper for the UART instruction-memory loader.
// Build option: LOADER_CHECKSUM_EN adds the trailing XOR checksum byte and its CSUM state.
package imem_loader_pkg;

   localparam logic [7:0] LOADER_SYNC = 8'hA5;

   typedef enum logic [1:0] {IDLE, LEN, DATA, CSUM} loader_state_t;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

   function automatic int clks_per_bit(input int clk_mhz, input int baud_rate);
      return (clk_mhz * 1_000_000) / baud_rate;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling.
// byte_valid / frame_err are single-cycle pulses one cycle after the stop-bit sample.
module uart_rx_byte
   import imem_loader_pkg::*;
#(
   parameter int CPB = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int CW = $clog2(CPB + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CPB - 1);

   logic            rx_meta, rx_sync, rx_prev;
   rx_state_t       st_q, st_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic [2:0]      bit_q, bit_n;
   logic [7:0]      sh_q, sh_n;
   logic            bv_n, fe_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         st_q       <= RX_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         sh_q       <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_sync    <= rx_meta;
         rx_prev    <= rx_sync;
         st_q       <= st_n;
         cnt_q      <= cnt_n;
         bit_q      <= bit_n;
         sh_q       <= sh_n;
         byte_valid <= bv_n;
         frame_err  <= fe_n;
      end
   end

   always_comb begin
      st_n  = st_q;
      cnt_n = cnt_q;
      bit_n = bit_q;
      sh_n  = sh_q;
      bv_n  = 1'b0;
      fe_n  = 1'b0;
      case (st_q)
         RX_IDLE: begin
            cnt_n = '0;
            bit_n = '0;
            if (rx_prev && !rx_sync) st_n = RX_START;
         end
         RX_START: begin
            // a start bit that is high again at half period was line noise
            if (cnt_q == HALF_LAST) begin
               cnt_n = '0;
               st_n  = rx_sync ? RX_IDLE : RX_BITS;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         RX_BITS: begin
            if (cnt_q == FULL_LAST) begin
               cnt_n = '0;
               sh_n  = {rx_sync, sh_q[7:1]};
               bit_n = bit_q + 1'b1;
               if (bit_q == 3'd7) st_n = RX_STOP;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_n = '0;
               st_n  = RX_IDLE;
               bv_n  = rx_sync;
               fe_n  = !rx_sync;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end
         default: st_n = RX_IDLE;
      endcase
   end

   assign byte_data = sh_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Frame parser that writes a UART-delivered program image into instruction RAM and holds the CPU meanwhile.
// Build option: LOADER_CHECKSUM_EN (frame ends with XOR checksum of the data bytes).
module imem_uart_loader
   import imem_loader_pkg::*;
#(
   parameter int clk_mhz   = 50,
   parameter int baud_rate = 115200,
   parameter int SIZE      = 64,
   parameter int w_addr    = $clog2(SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   output logic              imem_we,
   output logic [w_addr-1:0] imem_wa,
   output logic [31:0]       imem_wd,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int CPB = clks_per_bit(clk_mhz, baud_rate);

   logic       byte_valid, frame_err;
   logic [7:0] byte_data;

   uart_rx_byte #(.CPB(CPB)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .rx         (uart_rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   loader_state_t     st_q, st_n;
   logic [7:0]        n_q, n_n;
   logic [7:0]        wcnt_q, wcnt_n;
   logic [1:0]        idx_q, idx_n;
   logic [23:0]       word_q, word_n;
   logic [w_addr-1:0] wa_q, wa_n;
   logic [31:0]       wd_q, wd_n;
   logic              we_q, we_n;
   logic              done_q, done_n;
   logic              err_q, err_n;
   logic              hold_q, hold_n;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        csum_q, csum_n;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q   <= IDLE;
         n_q    <= '0;
         wcnt_q <= '0;
         idx_q  <= '0;
         word_q <= '0;
         wa_q   <= '0;
         wd_q   <= '0;
         we_q   <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         hold_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_q <= '0;
`endif
      end else begin
         st_q   <= st_n;
         n_q    <= n_n;
         wcnt_q <= wcnt_n;
         idx_q  <= idx_n;
         word_q <= word_n;
         wa_q   <= wa_n;
         wd_q   <= wd_n;
         we_q   <= we_n;
         done_q <= done_n;
         err_q  <= err_n;
         hold_q <= hold_n;
`ifdef LOADER_CHECKSUM_EN
         csum_q <= csum_n;
`endif
      end
   end

   always_comb begin
      st_n   = st_q;
      n_n    = n_q;
      wcnt_n = wcnt_q;
      idx_n  = idx_q;
      word_n = word_q;
      wa_n   = wa_q;
      wd_n   = wd_q;
      we_n   = 1'b0;
      done_n = done_q;
      err_n  = err_q;
      hold_n = hold_q;
`ifdef LOADER_CHECKSUM_EN
      csum_n = csum_q;
`endif
      // address advances the cycle after its strobe so wa is stable while we is high
      if (we_q) wa_n = wa_q + 1'b1;
      case (st_q)
         IDLE: begin
            if (byte_valid && byte_data == LOADER_SYNC) begin
               st_n   = LEN;
               hold_n = 1'b1;
               done_n = 1'b0;
               err_n  = 1'b0;
            end
         end
         LEN: begin
            if (frame_err) begin
               err_n = 1'b1;
               st_n  = IDLE;
            end else if (byte_valid) begin
               if (byte_data == 8'd0 || int'(byte_data) > SIZE) begin
                  err_n = 1'b1;
                  st_n  = IDLE;
               end else begin
                  n_n    = byte_data;
                  wa_n   = '0;
                  idx_n  = '0;
                  wcnt_n = '0;
                  st_n   = DATA;
`ifdef LOADER_CHECKSUM_EN
                  csum_n = '0;
`endif
               end
            end
         end
         DATA: begin
            if (frame_err) begin
               err_n = 1'b1;
               st_n  = IDLE;
            end else if (byte_valid) begin
               idx_n = idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
               csum_n = csum_q ^ byte_data;
`endif
               // lanes 0..2 accumulate by right shift; lane 3 completes the word
               if (idx_q == 2'd3) begin
                  we_n   = 1'b1;
                  wd_n   = {byte_data, word_q};
                  wcnt_n = wcnt_q + 8'd1;
`ifdef LOADER_CHECKSUM_EN
                  if (wcnt_n == n_q) st_n = CSUM;
`endif
               end else begin
                  word_n = {byte_data, word_q[23:8]};
               end
            end
`ifndef LOADER_CHECKSUM_EN
            else if (we_q && wcnt_q == n_q) begin
               done_n = 1'b1;
               hold_n = 1'b0;
               st_n   = IDLE;
            end
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         CSUM: begin
            if (frame_err) begin
               err_n = 1'b1;
               st_n  = IDLE;
            end else if (byte_valid) begin
               st_n = IDLE;
               if (byte_data == csum_q) begin
                  done_n = 1'b1;
                  hold_n = 1'b0;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
`endif
         default: st_n = IDLE;
      endcase
   end

   assign imem_we  = we_q;
   assign imem_wa  = wa_q;
   assign imem_wd  = wd_q;
   assign cpu_hold = hold_q;
   assign busy     = (st_q != IDLE);
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Randomized bench for imem_uart_loader against a byte-level frame model; 10 clocks per UART bit.
module tb_imem_uart_loader;

   localparam int SIZE = 64;
   localparam int WA   = $clog2(SIZE);
   localparam int CPB  = 10;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          uart_rx = 1'b1;
   logic          imem_we;
   logic [WA-1:0] imem_wa;
   logic [31:0]   imem_wd;
   logic          cpu_hold, busy, done, err;

   imem_uart_loader #(.clk_mhz(1), .baud_rate(100000), .SIZE(SIZE)) dut (
      .clk      (clk),
      .rst      (rst),
      .uart_rx  (uart_rx),
      .imem_we  (imem_we),
      .imem_wa  (imem_wa),
      .imem_wd  (imem_wd),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // observed write strobes
   int          got_wa[$];
   logic [31:0] got_wd[$];
   always @(negedge clk) begin
      if (rst && imem_we) begin
         got_wa.push_back(int'(imem_wa));
         got_wd.push_back(imem_wd);
      end
   end

   // reference model: frame parser over the received byte stream
   int          m_mode;  // 0 idle, 1 expect length, 2 data, 3 checksum
   int          m_n, m_k;
   logic [7:0]  m_cs;
   logic [31:0] m_word;
   bit          m_done, m_err, m_hold;
   int          exp_wa[$];
   logic [31:0] exp_wd[$];

   task automatic model_reset();
      m_mode = 0; m_n = 0; m_k = 0; m_cs = '0; m_word = '0;
      m_done = 0; m_err = 0; m_hold = 0;
      exp_wa.delete(); exp_wd.delete();
      got_wa.delete(); got_wd.delete();
   endtask

   task automatic model_byte(input logic [7:0] b, input bit ok);
      case (m_mode)
         0: if (ok && b == 8'hA5) begin
               m_mode = 1; m_hold = 1; m_done = 0; m_err = 0;
            end
         1: if (!ok || b == 8'd0 || int'(b) > SIZE) begin
               m_err = 1; m_mode = 0;
            end else begin
               m_n = int'(b); m_k = 0; m_cs = '0; m_mode = 2;
            end
         2: if (!ok) begin
               m_err = 1; m_mode = 0;
            end else begin
               m_word[8*(m_k%4) +: 8] = b;
               m_cs = m_cs ^ b;
               m_k++;
               if (m_k % 4 == 0) begin
                  exp_wa.push_back(m_k/4 - 1);
                  exp_wd.push_back(m_word);
               end
               if (m_k == 4*m_n) begin
                  if (CSUM_EN) m_mode = 3;
                  else begin m_done = 1; m_hold = 0; m_mode = 0; end
               end
            end
         default: begin
            if (ok && b == m_cs) begin m_done = 1; m_hold = 0; end
            else m_err = 1;
            m_mode = 0;
         end
      endcase
   endtask

   logic [7:0] tx_b[$];
   bit         tx_ok[$];

   task automatic push(input logic [7:0] b, input bit ok = 1'b1);
      tx_b.push_back(b);
      tx_ok.push_back(ok);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok);
      uart_rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      uart_rx = ok;
      repeat (CPB) @(posedge clk);
      uart_rx = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic check_all(input string tag);
      int n;
      chk({tag, ".nwr"}, 32'(got_wa.size()), 32'(exp_wa.size()));
      n = (got_wa.size() < exp_wa.size()) ? got_wa.size() : exp_wa.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s.wa%0d", tag, i), 32'(got_wa[i]), 32'(exp_wa[i]));
         chk($sformatf("%s.wd%0d", tag, i), got_wd[i], exp_wd[i]);
      end
      chk({tag, ".done"}, 32'(done), 32'(m_done));
      chk({tag, ".err"},  32'(err),  32'(m_err));
      chk({tag, ".hold"}, 32'(cpu_hold), 32'(m_hold));
      chk({tag, ".busy"}, 32'(busy), 32'(m_mode != 0));
      got_wa.delete(); got_wd.delete();
      exp_wa.delete(); exp_wd.delete();
   endtask

   task automatic play(input string tag);
      for (int i = 0; i < tx_b.size(); i++) begin
         send_byte(tx_b[i], tx_ok[i]);
         model_byte(tx_b[i], tx_ok[i]);
      end
      tx_b.delete(); tx_ok.delete();
      repeat (5) @(posedge clk);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk({tag, ".we"},   32'(imem_we),  32'd0);
      chk({tag, ".wa"},   32'(imem_wa),  32'd0);
      chk({tag, ".wd"},   imem_wd,       32'd0);
      chk({tag, ".hold"}, 32'(cpu_hold), 32'd0);
      chk({tag, ".busy"}, 32'(busy),     32'd0);
      chk({tag, ".done"}, 32'(done),     32'd0);
      chk({tag, ".err"},  32'(err),      32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
   endtask

   task automatic push_example(input logic [7:0] cs);
      push(8'hA5); push(8'h02);
      push(8'h13); push(8'h05); push(8'h50); push(8'h00);
      push(8'h13); push(8'h00); push(8'h00); push(8'h00);
      push(cs);
   endtask

   initial begin
      logic [7:0] b, cs;
      int n, kind, pos;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset("rst0");

      push_example(8'h55);                       play("good");
      push_example(8'h54);                       play("badcs");
      push(8'hA5); push(8'h00);                  play("len0");
      push(8'hA5); push(8'h41);                  play("len65");

      push(8'hA5); push(8'h02); push(8'h13); push(8'h05, 1'b0);
      play("stoperr");
      push_example(8'h55);                       play("after_err");

      push(8'h00); push(8'hFF); push(8'h13);
      push_example(8'h55);                       play("junk");

      push(8'hA5); push(8'h02); push(8'h13); push(8'h05); push(8'h50);
      play("partial");
      do_reset("rst_mid");
      push_example(8'h55);                       play("after_rst");

      // largest legal image
      push(8'hA5); push(8'(SIZE)); cs = '0;
      for (int i = 0; i < 4*SIZE; i++) begin
         b = 8'($urandom); cs ^= b; push(b);
      end
      push(cs);                                  play("full");

      for (int r = 0; r < 12; r++) begin
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            do b = 8'($urandom); while (b == 8'hA5);
            push(b);
         end
         n = $urandom_range(1, 4);
         kind = $urandom_range(0, 9);
         push(8'hA5);
         if (kind == 0) begin
            push(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(SIZE + 1, 255)));
         end else begin
            push(8'(n)); cs = '0;
            pos = $urandom_range(0, 4*n - 1);
            for (int i = 0; i < 4*n; i++) begin
               b = 8'($urandom); cs ^= b;
               if (kind == 1 && i == pos) begin
                  push(b, 1'b0);
                  break;
               end
               push(b);
            end
            if (kind != 1) push((kind == 2) ? (cs ^ 8'($urandom_range(1, 255))) : cs);
         end
         play($sformatf("rnd%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
